gb_stage_sched: RTL and testbench
=================================

# gb_stage_sched

Issue scheduler for the Gaussian-blur streaming pipeline. Each decision cycle it inspects the AXI-stream handshake inputs and the in/slice/stencil FIFO flags. It grants at most one pipeline stage (input accept, 1-D line buffer, 2-D line buffer, output emit) and pulses `step` with a one-hot instruction select to the blur datapath. It also counts input pixels and output pixels per frame, and signals frame completion.

## Interface
Parameters:
- IMG_W, 480, image width in pixels (≥ WIN)
- IMG_H, 640, image height in pixels (≥ WIN)
- WIN, 9, stencil edge length; output frame is (IMG_W-WIN+1)×(IMG_H-WIN+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  start a frame; sampled in IDLE only
- abort  in  1  abandon frame; return to IDLE next cycle
- arg_1_TVALID  in  1  input pixel valid
- arg_0_TREADY  in  1  output sink ready
- in_stream_empty / in_stream_full  in  1 each  input FIFO flags
- slice_stream_empty / slice_stream_full  in  1 each  slice FIFO flags
- stencil_stream_empty / stencil_stream_full  in  1 each  stencil FIFO flags
- step  out  1  datapath advance strobe
- instr_sel  out  4  one-hot stage select: [0] IN, [1] LB1D, [2] LB2D, [3] OUT
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at frame end
- in_cnt  out  clog2(IMG_W*IMG_H+1)  pixels accepted this frame
- out_cnt  out  clog2(OUT_TOTAL+1)  pixels emitted this frame

## Operation
- FSM states: IDLE, ARB, ISSUE, SETTLE, DONE.
- IDLE: counters held. On `go`, clear counters and go to ARB.
- ARB: evaluate eligibility.
  - IN: arg_1_TVALID & !in_stream_full & in_cnt < IMG_W*IMG_H
  - LB1D: !in_stream_empty & !slice_stream_full
  - LB2D: !slice_stream_empty & !stencil_stream_full
  - OUT: !stencil_stream_empty & arg_0_TREADY & out_cnt < OUT_TOTAL
  - If in_cnt == IMG_W*IMG_H and out_cnt == OUT_TOTAL, go to DONE.
  - Else if any stage is eligible, register the one-hot grant and go to ISSUE.
  - Else stay in ARB.
- ISSUE: step=1 and instr_sel=grant for exactly one cycle. in_cnt increments if the grant is IN; out_cnt increments if the grant is OUT. Next state SETTLE.
- SETTLE: one idle cycle so the datapath flags reflect the issued step. Next state ARB.
- DONE: frame_done=1 for one cycle, then IDLE. Counters hold their final values until the next `go`.
- Arbitration by default is fixed priority, downstream first: OUT > LB2D > LB1D > IN. This drains the pipeline first, which prevents FIFO deadlock.
- abort in any non-IDLE state: next state IDLE, step=0, counters unchanged. This takes priority over all other transitions.
- OUT_TOTAL = (IMG_W-WIN+1)*(IMG_H-WIN+1). Counters saturate at their totals and never wrap.

## Timing
- Reset values: state IDLE, step=0, instr_sel=0, busy=0, frame_done=0, in_cnt=0, out_cnt=0.
- Reset asserted mid-frame overrides everything on the same edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: `go` → first possible `step` is 2 cycles (IDLE→ARB→ISSUE). Maximum issue rate is one step per 3 cycles (ARB, ISSUE, SETTLE).
- instr_sel is nonzero only while step=1, and is always one-hot when nonzero.
- Inputs are sampled only in ARB. Changes during ISSUE or SETTLE are ignored.
- go while busy is ignored.
- go and abort together in IDLE: abort wins, FSM stays IDLE.
- Last OUT issue → frame_done: 3 cycles (SETTLE, ARB, DONE).

## Configuration
- GB_SCHED_RR_EN defined: round-robin arbitration. A pointer starts at IN after `go`. Search order starts at the stage after the last granted one. The pointer advances only on a grant.
- GB_SCHED_RR_EN undefined: fixed downstream-first priority as above. No pointer register is present.

## Structure
- Shared package gb_sched_pkg contains:
  - state enum
  - stage index constants STG_IN=0, STG_1D=1, STG_2D=2, STG_OUT=3
  - NUM_STG=4
  - `function` computing OUT_TOTAL
- One sub-module, gb_sched_arbiter: takes a 4-bit eligibility vector (plus last-grant input when RR is compiled in) and returns a one-hot grant. The FSM, counters and output registers stay in gb_stage_sched.

## Test plan
Use IMG_W=IMG_H=10, WIN=9, so the input total is 100 and OUT_TOTAL is 4.
- Reset/idle: assert rst 2 cycles then go=0 → all outputs 0 and step never asserts.
- Single issue: go, arg_1_TVALID=1, all FIFOs empty → step at cycle 2 with instr_sel=4'b0001, in_cnt=1; next step no earlier than cycle 5.
- Priority: in ARB, arg_1_TVALID=1, in_stream_empty=0, stencil_stream_empty=0, arg_0_TREADY=1 → instr_sel=4'b1000 (default build). With GB_SCHED_RR_EN and last grant IN → 4'b0010.
- Backpressure: stencil_stream_empty=0, arg_0_TREADY=0 with all other stages ineligible → FSM stays in ARB with step=0 until TREADY=1, then OUT issues.
- Full frame: a model datapath drives the flags → exactly 100 IN and 4 OUT grants, frame_done pulses once, busy falls the next cycle, in_cnt=100, out_cnt=4.
- Abort/reset mid-frame: abort after 37 IN grants → IDLE next cycle and in_cnt=37 held; a new go clears in_cnt to 0. rst at the same point → all reset values.

Source files
------------

// File: rtl/gb_sched_pkg.sv
// Shared types and constants for the Gaussian-blur stage scheduler.
// Optional feature macro: GB_SCHED_RR_EN (round-robin arbitration).
package gb_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_STG = 4;
    localparam int unsigned STG_W   = 2;

    localparam int unsigned STG_IN  = 0;
    localparam int unsigned STG_1D  = 1;
    localparam int unsigned STG_2D  = 2;
    localparam int unsigned STG_OUT = 3;

    // Number of valid stencil positions in one frame.
    function automatic int unsigned out_total(input int unsigned img_w,
                                              input int unsigned img_h,
                                              input int unsigned win);
        return (img_w - win + 1) * (img_h - win + 1);
    endfunction

    // Index of the set bit in a one-hot grant (0 when no bit is set).
    function automatic logic [STG_W-1:0] grant_idx(input logic [NUM_STG-1:0] grant);
        logic [STG_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_STG; i++) begin
            if (grant[i]) idx = STG_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gb_sched_arbiter.sv
// One-hot grant selection among eligible pipeline stages.
// GB_SCHED_RR_EN: round-robin starting after the last granted stage;
// otherwise fixed downstream-first priority (OUT > LB2D > LB1D > IN).
module gb_sched_arbiter
    import gb_sched_pkg::*;
(
    input  logic [NUM_STG-1:0] elig,
`ifdef GB_SCHED_RR_EN
    input  logic [STG_W-1:0]   last_grant,
`endif
    output logic [NUM_STG-1:0] grant_c
);

`ifdef GB_SCHED_RR_EN
    // Walk the stages starting one past the last grant; the last grant itself is checked last.
    always_comb begin : rr_pick
        logic             found;
        logic [STG_W-1:0] idx;
        grant_c = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= NUM_STG; i++) begin
            idx = last_grant + STG_W'(i);
            if (!found && elig[idx]) begin
                grant_c[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`else
    // Downstream stages first so the pipeline drains before it is refilled.
    always_comb begin
        grant_c = '0;
        if (elig[STG_OUT])     grant_c[STG_OUT] = 1'b1;
        else if (elig[STG_2D]) grant_c[STG_2D]  = 1'b1;
        else if (elig[STG_1D]) grant_c[STG_1D]  = 1'b1;
        else if (elig[STG_IN]) grant_c[STG_IN]  = 1'b1;
    end
`endif

endmodule

// File: rtl/gb_stage_sched.sv
// Issue scheduler for the Gaussian-blur streaming pipeline: grants one stage
// per ARB/ISSUE/SETTLE round and counts pixels in and out of each frame.
// Optional feature macro: GB_SCHED_RR_EN (round-robin arbitration).
module gb_stage_sched
    import gb_sched_pkg::*;
#(
    parameter int unsigned IMG_W = 480,
    parameter int unsigned IMG_H = 640,
    parameter int unsigned WIN   = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic abort,
    input  logic arg_1_TVALID,
    input  logic arg_0_TREADY,
    input  logic in_stream_empty,
    input  logic in_stream_full,
    input  logic slice_stream_empty,
    input  logic slice_stream_full,
    input  logic stencil_stream_empty,
    input  logic stencil_stream_full,
    output logic step,
    output logic [NUM_STG-1:0] instr_sel,
    output logic busy,
    output logic frame_done,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0] in_cnt,
    output logic [$clog2(out_total(IMG_W, IMG_H, WIN)+1)-1:0] out_cnt
);

    localparam int unsigned IN_TOTAL  = IMG_W * IMG_H;
    localparam int unsigned OUT_TOTAL = out_total(IMG_W, IMG_H, WIN);
    localparam int unsigned IN_CNT_W  = $clog2(IN_TOTAL + 1);
    localparam int unsigned OUT_CNT_W = $clog2(OUT_TOTAL + 1);

    state_t             state;
    logic [NUM_STG-1:0] elig_c;
    logic [NUM_STG-1:0] grant_c;
    logic               in_done_c;
    logic               out_done_c;

`ifdef GB_SCHED_RR_EN
    logic [STG_W-1:0]   last_grant;
`endif

    assign in_done_c  = (in_cnt  == IN_CNT_W'(IN_TOTAL));
    assign out_done_c = (out_cnt == OUT_CNT_W'(OUT_TOTAL));

    // Per-stage eligibility from stream handshakes and FIFO flags.
    always_comb begin
        elig_c          = '0;
        elig_c[STG_IN]  = arg_1_TVALID && !in_stream_full && !in_done_c;
        elig_c[STG_1D]  = !in_stream_empty && !slice_stream_full;
        elig_c[STG_2D]  = !slice_stream_empty && !stencil_stream_full;
        elig_c[STG_OUT] = !stencil_stream_empty && arg_0_TREADY && !out_done_c;
    end

    gb_sched_arbiter u_arbiter (
        .elig       (elig_c),
`ifdef GB_SCHED_RR_EN
        .last_grant (last_grant),
`endif
        .grant_c    (grant_c)
    );

    // Scheduler FSM with registered strobes and saturating frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step       <= 1'b0;
            instr_sel  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
`ifdef GB_SCHED_RR_EN
            last_grant <= STG_W'(STG_OUT);
`endif
        end else begin
            step       <= 1'b0;
            instr_sel  <= '0;
            frame_done <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go && !abort) begin
                            state   <= ST_ARB;
                            busy    <= 1'b1;
                            in_cnt  <= '0;
                            out_cnt <= '0;
`ifdef GB_SCHED_RR_EN
                            // Search after OUT, i.e. the first search starts at IN.
                            last_grant <= STG_W'(STG_OUT);
`endif
                        end
                    end
                    ST_ARB: begin
                        if (in_done_c && out_done_c) begin
                            state      <= ST_DONE;
                            frame_done <= 1'b1;
                        end else if (|grant_c) begin
                            state     <= ST_ISSUE;
                            step      <= 1'b1;
                            instr_sel <= grant_c;
                            if (grant_c[STG_IN] && !in_done_c)
                                in_cnt <= in_cnt + IN_CNT_W'(1);
                            if (grant_c[STG_OUT] && !out_done_c)
                                out_cnt <= out_cnt + OUT_CNT_W'(1);
`ifdef GB_SCHED_RR_EN
                            last_grant <= grant_idx(grant_c);
`endif
                        end
                    end
                    ST_ISSUE:  state <= ST_SETTLE;
                    ST_SETTLE: state <= ST_ARB;
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gb_stage_sched.sv
// Self-checking bench for gb_stage_sched with a 10x10 image and 9x9 stencil.
`timescale 1ns/1ps
module tb_gb_stage_sched;

    localparam int IMG_W   = 10;
    localparam int IMG_H   = 10;
    localparam int WIN     = 9;
    localparam int IN_TOT  = IMG_W * IMG_H;
    localparam int OUT_TOT = (IMG_W - WIN + 1) * (IMG_H - WIN + 1);
    localparam int DEPTH   = 2;

    logic       clk = 1'b0;
    logic       rst, go, abort, tv, tr;
    logic       in_e, in_f, sl_e, sl_f, st_e, st_f;
    logic       step, busy, frame_done;
    logic [3:0] instr_sel;
    logic [6:0] in_cnt;
    logic [2:0] out_cnt;

    int checks = 0;
    int errors = 0;

    // Reference datapath model: pixel/frame counts and FIFO occupancies.
    int m_in, m_out, c_in, c_sl, c_st, lb1_n, lb2_n, rr_next;

    always #5 clk = ~clk;

    gb_stage_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .go                   (go),
        .abort                (abort),
        .arg_1_TVALID         (tv),
        .arg_0_TREADY         (tr),
        .in_stream_empty      (in_e),
        .in_stream_full       (in_f),
        .slice_stream_empty   (sl_e),
        .slice_stream_full    (sl_f),
        .stencil_stream_empty (st_e),
        .stencil_stream_full  (st_f),
        .step                 (step),
        .instr_sel            (instr_sel),
        .busy                 (busy),
        .frame_done           (frame_done),
        .in_cnt               (in_cnt),
        .out_cnt              (out_cnt)
    );

    // Expected grant from the stage rules and the arbitration policy.
    function automatic logic [3:0] ref_grant();
        bit         e[4];
        logic [3:0] g;
        g    = '0;
        e[0] = tv && !in_f && (m_in < IN_TOT);
        e[1] = !in_e && !sl_f;
        e[2] = !sl_e && !st_f;
        e[3] = !st_e && tr && (m_out < OUT_TOT);
`ifdef GB_SCHED_RR_EN
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (rr_next + k) % 4;
            if (g == 4'b0 && e[s]) g[s] = 1'b1;
        end
`else
        for (int s = 3; s >= 0; s--) begin
            if (g == 4'b0 && e[s]) g[s] = 1'b1;
        end
`endif
        return g;
    endfunction

    task automatic model_reset();
        m_in = 0; m_out = 0; c_in = 0; c_sl = 0; c_st = 0;
        lb1_n = 0; lb2_n = 0; rr_next = 0;
    endtask

    // Line buffers emit a slice once WIN rows are buffered and a stencil once WIN columns are.
    task automatic apply_step(input logic [3:0] g);
        if (g[0]) begin m_in++; c_in++; end
        if (g[1]) begin
            c_in--; lb1_n++;
            if ((lb1_n - 1) / IMG_W >= WIN - 1) c_sl++;
        end
        if (g[2]) begin
            c_sl--; lb2_n++;
            if ((lb2_n - 1) % IMG_W >= WIN - 1) c_st++;
        end
        if (g[3]) begin m_out++; c_st--; end
        for (int k = 0; k < 4; k++) if (g[k]) rr_next = (k + 1) % 4;
    endtask

    task automatic drive_flags();
        in_e = (c_in == 0); in_f = (c_in == DEPTH);
        sl_e = (c_sl == 0); sl_f = (c_sl == DEPTH);
        st_e = (c_st == 0); st_f = (c_st == DEPTH);
    endtask

    task automatic go_idle();
        @(negedge clk);
        go = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_steps(input int target, output bit ok);
        int seen, cyc;
        seen = 0; cyc = 0;
        while (seen < target && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (step === 1'b1) seen++;
        end
        ok = (seen == target);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; abort = 1'b0; tv = 1'b0; tr = 1'b0;
        in_e = 1'b1; in_f = 1'b0; sl_e = 1'b1; sl_f = 1'b0; st_e = 1'b1; st_f = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({step, instr_sel, busy, frame_done, in_cnt, out_cnt} !== 17'b0) begin
            errors++;
            $display("FAIL reset_values: got %h required 0",
                     {step, instr_sel, busy, frame_done, in_cnt, out_cnt});
        end
        tv = 1'b1; tr = 1'b1; st_e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (step !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_step: step=%b busy=%b required 0 0", step, busy);
            end
        end
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL go_abort_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_single_issue();
        go_idle();
        tv = 1'b1; tr = 1'b0;
        in_e = 1'b1; in_f = 1'b0; sl_e = 1'b1; sl_f = 1'b0; st_e = 1'b1; st_f = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (step !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_arb: step=%b busy=%b required 0 1", step, busy);
        end
        @(negedge clk);
        checks++;
        if (step !== 1'b1 || instr_sel !== 4'b0001 || in_cnt !== 7'd1) begin
            errors++;
            $display("FAIL single_issue: step=%b sel=%b in_cnt=%0d required 1 0001 1",
                     step, instr_sel, in_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (step !== 1'b0 || instr_sel !== 4'b0) begin
                errors++;
                $display("FAIL single_gap: step=%b sel=%b required 0 0000", step, instr_sel);
            end
        end
        @(negedge clk);
        checks++;
        if (step !== 1'b1 || in_cnt !== 7'd2) begin
            errors++;
            $display("FAIL single_second: step=%b in_cnt=%0d required 1 2", step, in_cnt);
        end
    endtask

    task automatic test_priority();
        go_idle();
        tv = 1'b1; tr = 1'b1;
        in_e = 1'b0; in_f = 1'b0; sl_e = 1'b1; sl_f = 1'b0; st_e = 1'b0; st_f = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        checks++;
`ifdef GB_SCHED_RR_EN
        if (step !== 1'b1 || instr_sel !== 4'b0001) begin
            errors++;
            $display("FAIL priority_rr_first: step=%b sel=%b required 1 0001", step, instr_sel);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (step !== 1'b1 || instr_sel !== 4'b0010) begin
            errors++;
            $display("FAIL priority_rr_next: step=%b sel=%b required 1 0010", step, instr_sel);
        end
`else
        if (step !== 1'b1 || instr_sel !== 4'b1000) begin
            errors++;
            $display("FAIL priority_fixed: step=%b sel=%b required 1 1000", step, instr_sel);
        end
`endif
    endtask

    task automatic test_backpressure();
        go_idle();
        tv = 1'b0; tr = 1'b0;
        in_e = 1'b1; in_f = 1'b0; sl_e = 1'b1; sl_f = 1'b0; st_e = 1'b0; st_f = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (step !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall: step=%b busy=%b required 0 1", step, busy);
            end
        end
        tr = 1'b1;
        @(negedge clk);
        checks++;
        if (step !== 1'b1 || instr_sel !== 4'b1000 || out_cnt !== 3'd1) begin
            errors++;
            $display("FAIL bp_release: step=%b sel=%b out_cnt=%0d required 1 1000 1",
                     step, instr_sel, out_cnt);
        end
    endtask

    task automatic test_full_frame();
        int         arb_cyc, n;
        bit         fin;
        logic [3:0] exp_g;
        logic [6:0] exp_o, got_o;
        go_idle();
        model_reset();
        drive_flags();
        tv = ($urandom_range(0, 3) != 0);
        tr = ($urandom_range(0, 3) != 0);
        go = 1'b1;
        arb_cyc = 1; n = 0; fin = 1'b0;
        while (!fin && n < 5000) begin
            @(negedge clk);
            n++;
            go = 1'b0;
            exp_g = '0;
            if (n == arb_cyc + 1) begin
                if (m_in == IN_TOT && m_out == OUT_TOT) begin
                    exp_o = {1'b1, 1'b0, 4'b0, 1'b1};
                    fin = 1'b1;
                end else begin
                    exp_g = ref_grant();
                    exp_o = {1'b1, |exp_g, exp_g, 1'b0};
                    arb_cyc = (exp_g != 4'b0) ? n + 2 : n;
                end
            end else begin
                exp_o = {1'b1, 1'b0, 4'b0, 1'b0};
            end
            got_o = {busy, step, instr_sel, frame_done};
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL frame_cycle %0d: busy/step/sel/done=%b required %b", n, got_o, exp_o);
            end
            if (exp_g != 4'b0) begin
                apply_step(exp_g);
                checks++;
                if (in_cnt !== 7'(m_in) || out_cnt !== 3'(m_out)) begin
                    errors++;
                    $display("FAIL frame_counts: in=%0d out=%0d required %0d %0d",
                             in_cnt, out_cnt, m_in, m_out);
                end
            end
            tv = ($urandom_range(0, 3) != 0);
            tr = ($urandom_range(0, 3) != 0);
            drive_flags();
        end
        if (!fin) begin
            errors++;
            $display("FAIL frame_timeout: in=%0d out=%0d after %0d cycles", m_in, m_out, n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || step !== 1'b0 ||
            in_cnt !== 7'd100 || out_cnt !== 3'd4) begin
            errors++;
            $display("FAIL frame_end: busy=%b done=%b step=%b in=%0d out=%0d required 0 0 0 100 4",
                     busy, frame_done, step, in_cnt, out_cnt);
        end
    endtask

    task automatic test_abort_reset();
        bit ok;
        go_idle();
        tv = 1'b1; tr = 1'b0;
        in_e = 1'b1; in_f = 1'b0; sl_e = 1'b1; sl_f = 1'b0; st_e = 1'b1; st_f = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_steps(37, ok);
        checks++;
        if (!ok || in_cnt !== 7'd37) begin
            errors++;
            $display("FAIL abort_reach37: ok=%b in_cnt=%0d required 1 37", ok, in_cnt);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || step !== 1'b0 || in_cnt !== 7'd37) begin
            errors++;
            $display("FAIL abort_idle: busy=%b step=%b in_cnt=%0d required 0 0 37", busy, step, in_cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_cnt !== 7'd37) begin
            errors++;
            $display("FAIL abort_hold: busy=%b in_cnt=%0d required 0 37", busy, in_cnt);
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_cnt !== 7'd0) begin
            errors++;
            $display("FAIL abort_regoclear: busy=%b in_cnt=%0d required 1 0", busy, in_cnt);
        end
        wait_steps(37, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (!ok || {step, instr_sel, busy, frame_done, in_cnt, out_cnt} !== 17'b0) begin
            errors++;
            $display("FAIL midframe_reset: ok=%b outputs=%h required 1 0", ok,
                     {step, instr_sel, busy, frame_done, in_cnt, out_cnt});
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_priority();
        test_backpressure();
        test_full_frame();
        test_full_frame();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
